// File: rtl/present_enc_sched.sv
// present_enc_sched: request/response scheduler around a masked PRESENT encryption core.
// Optional watchdog (RUN -> ERR on missing core_valid_out) enabled by PRESENT_SCHED_WDOG_EN.
module present_enc_sched #(
   parameter int d          = 2,
   parameter int Nbits      = 64,
   parameter int LATENCY    = 156,
   parameter int WDOG_SLACK = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               core_start,
   input  logic               core_valid_out,
   input  logic [d*Nbits-1:0] core_ct,
   output logic               rnd_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [d*Nbits-1:0] out_ct,
   output logic               busy,
   output logic               err
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD, ERR} state_t;
   localparam logic [15:0] WDOG_LIM = 16'(LATENCY + WDOG_SLACK);
`ifdef PRESENT_SCHED_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif
   state_t      state;
   logic [15:0] cnt;
   // reset gates in_ready so no start pulse escapes while rst is held
   assign in_ready   = state == IDLE && !rst;
   assign core_start = in_valid && in_ready;
   assign rnd_en     = state == RUN || core_start;
   assign out_valid  = state == HOLD;
   assign busy       = state != IDLE;
`ifdef PRESENT_SCHED_WDOG_EN
   assign err        = state == ERR;
`else
   assign err        = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         out_ct <= '0;
      end else begin
         case (state)
            IDLE: if (core_start) begin
               state <= RUN;
               cnt   <= '0;
            end
            RUN: begin
               cnt <= cnt == 16'hFFFF ? cnt : cnt + 16'd1;
               // a capture wins over a simultaneous timeout
               if (core_valid_out) begin
                  out_ct <= core_ct;
                  state  <= HOLD;
               end else if (WDOG_EN && cnt >= WDOG_LIM) state <= ERR;
            end
            HOLD: if (out_ready) state <= IDLE;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_present_enc_sched.sv
// tb_present_enc_sched: directed self-checking bench for present_enc_sched.
// Watchdog expectations follow PRESENT_SCHED_WDOG_EN when it is defined for the build.
module tb_present_enc_sched;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         core_start;
   logic         core_valid_out = 1'b0;
   logic [127:0] core_ct = '0;
   logic         rnd_en;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_ct;
   logic         busy;
   logic         err;
   int tests = 0;
   int fails = 0;
   localparam logic [127:0] V1 = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [127:0] V2 = 128'hdeadbeefcafef00d_0011223344556677;
   localparam logic [127:0] V3 = 128'h5555aaaa5555aaaa_a5a5a5a5a5a5a5a5;
`ifdef PRESENT_SCHED_WDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   present_enc_sched dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .core_start(core_start), .core_valid_out(core_valid_out), .core_ct(core_ct),
      .rnd_en(rnd_en), .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start();
      in_valid = 1'b1;
      #1;
      chk("start_core_start", core_start, 1'b1);
      chk("start_rnd_en", rnd_en, 1'b1);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      tick(2);
      in_valid = 1'b1;
      #1;
      chk("rst_core_start", core_start, 1'b0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_out_ct", out_ct, '0);
      chk("rst_rnd_en", rnd_en, 1'b0);

      start();
      chk("run_busy", busy, 1'b1);
      chk("run_in_ready", in_ready, 1'b0);
      chk("run_rnd_en", rnd_en, 1'b1);
      in_valid = 1'b1;
      #1;
      chk("run_no_start", core_start, 1'b0);
      in_valid = 1'b0;
      tick(155);
      chk("run_busy_155", busy, 1'b1);
      core_valid_out = 1'b1;
      core_ct = V1;
      out_ready = 1'b1;
      tick();
      core_valid_out = 1'b0;
      core_ct = '0;
      #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_ct", out_ct, V1);
      chk("hold_rnd_en", rnd_en, 1'b0);
      chk("hold_in_ready", in_ready, 1'b0);
      tick();
      chk("done_out_valid", out_valid, 1'b0);
      chk("done_in_ready", in_ready, 1'b1);
      chk("done_out_ct_kept", out_ct, V1);
      chk("done_busy", busy, 1'b0);

      out_ready = 1'b0;
      start();
      tick(4);
      core_valid_out = 1'b1;
      core_ct = V2;
      tick();
      core_valid_out = 1'b0;
      for (int i = 0; i < 10; i++) begin
         core_valid_out = (i == 3);
         core_ct = V3;
         in_valid = 1'b1;
         #1;
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_out_ct", out_ct, V2);
         chk("stall_no_start", core_start, 1'b0);
         tick();
      end
      core_valid_out = 1'b0;
      in_valid = 1'b0;
      chk("stall_out_ct_end", out_ct, V2);
      out_ready = 1'b1;
      tick();
      chk("stall_done_valid", out_valid, 1'b0);
      chk("stall_done_ready", in_ready, 1'b1);
      out_ready = 1'b0;

      start();
      tick(50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_ct", out_ct, '0);
      core_valid_out = 1'b1;
      core_ct = V1;
      tick();
      core_valid_out = 1'b0;
      chk("late_cvo_out_valid", out_valid, 1'b0);
      chk("late_cvo_out_ct", out_ct, '0);
      chk("late_cvo_busy", busy, 1'b0);

      start();
      tick(164);
      chk("wd_pre_err", err, 1'b0);
      chk("wd_pre_busy", busy, 1'b1);
      tick();
      chk("wd_err", err, WD);
      chk("wd_busy", busy, 1'b1);
      chk("wd_in_ready", in_ready, 1'b0);
      chk("wd_rnd_en", rnd_en, !WD);
      tick(5);
      in_valid = 1'b1;
      #1;
      chk("wd_err_held", err, WD);
      chk("wd_no_start", core_start, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("wd_rst_err", err, 1'b0);
      chk("wd_rst_ready", in_ready, 1'b1);

      start();
      tick(164);
      core_valid_out = 1'b1;
      core_ct = V3;
      tick();
      core_valid_out = 1'b0;
      chk("tie_out_valid", out_valid, 1'b1);
      chk("tie_err", err, 1'b0);
      chk("tie_out_ct", out_ct, V3);
      out_ready = 1'b1;
      tick();
      chk("tie_done_ready", in_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
